clk_div_ratio_ctrl: RTL and testbench
=====================================

// Module: clk_div_ratio_ctrl
// PURPOSE
//  Sequences run-time division-ratio changes for the configurable integer clock divider.
//  Accepts a new ratio over a valid/ready handshake and drives the divider's ratio and enable inputs.
//  Sequence: waits for a falling edge of the divided clock, gates the divider, loads the ratio,
//  re-enables, then waits one settle interval before acknowledging.
//  Sits in the ref-clock domain between the register file/config master and the divider.
// PARAMETERS
//  RATIO_WIDTH   4  width of division ratio (matches divider)
//  DEFAULT_RATIO 1  ratio driven out of reset (0/1 = divider bypass)
//  GATE_CYCLES   2  ref-clock cycles o_clk_en is held low during a change (>=1)
// PORTS
//  i_ref_clk    in  1            reference clock; all logic on posedge
//  i_rst_n      in  1            reset, asynchronous, active-low
//  i_req_valid  in  1            new-ratio request valid
//  i_req_ratio  in  RATIO_WIDTH  requested ratio
//  o_req_ready  out 1            request accepted when valid&ready (high only in IDLE)
//  i_div_clk    in  1            divider output, monitored (generated from i_ref_clk flops)
//  o_div_ratio  out RATIO_WIDTH  ratio to divider, registered
//  o_clk_en     out 1            enable to divider, registered
//  o_busy       out 1            high whenever state != IDLE
//  o_done       out 1            1-cycle pulse: request completed
// BEHAVIOUR
//  Reset (async): state=BOOT, o_div_ratio=DEFAULT_RATIO, o_clk_en=0, o_done=0, counters=0.
//  BOOT: on first clock after reset release, o_clk_en<=1, go to IDLE.
//  IDLE: o_req_ready=1 (combinational from state). Handshake in cycle N latches i_req_ratio.
//   - If latched ratio == o_div_ratio: o_done=1 in cycle N+1, stay IDLE; outputs unchanged.
//   - Otherwise go to DRAIN at N+1. If current o_div_ratio<2 (bypass), go straight to GATE.
//  DRAIN: register i_div_clk each cycle (div_q).
//   - Exit on falling edge (div_q==1 && i_div_clk==0): o_clk_en<=0, go to GATE.
//   - Exit on timeout: drain counter reaches 2**(RATIO_WIDTH+1)-1 cycles. Same exit action.
//  GATE: o_clk_en held 0 for exactly GATE_CYCLES cycles, then o_div_ratio<=latched ratio; go to LOAD.
//  LOAD: 1 cycle with new ratio stable and enable low. Then o_clk_en<=1, go to SETTLE.
//  SETTLE: count max(new ratio,1) cycles.
//   - On last count, go to IDLE; o_done=1 for the first IDLE cycle.
//   - If the new ratio is 0/1, one settle cycle.
//  o_div_ratio changes only while o_clk_en==0; never changes in IDLE/DRAIN/SETTLE.
//  Requests while busy: ready=0, ignored; no queueing. i_req_ratio is sampled only at handshake.
//  Settle counter is RATIO_WIDTH+1 bits wide. Drain counter is RATIO_WIDTH+2 bits, saturating. No wrap.
//  Reset mid-sequence: in-flight request dropped, no o_done, returns to reset values above.
//  Back-to-back: a new request may handshake in the same cycle o_done pulses (IDLE).
// TESTING
//  1. Reset, release -> o_clk_en=0 for first edge, then 1. o_div_ratio=1, ready=1, busy=0.
//  2. From ratio 1, request 4 -> DRAIN skipped; en low 2 cycles; ratio=4 while en=0.
//     Then en=1, 4 settle cycles, then done pulse. Divider output period=4 ref cycles.
//  3. At ratio 6, request 3 -> en falls only on the cycle after an i_div_clk falling edge.
//     No divided-clock pulse shorter than 1 ref cycle.
//  4. Request 5 while already 5 -> done pulse next cycle; busy never asserted; en stays 1.
//  5. Drive i_div_clk constant 1 at ratio 6, request 2 -> DRAIN exits at 31-cycle timeout,
//     then normal sequence.
//  6. Assert i_rst_n low during GATE -> immediate ratio=DEFAULT_RATIO, en=0, no done.
//     Valid held during busy is ignored.

Source files
------------

// File: rtl/clk_div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clk_div_ratio_ctrl
//  Description : Sequences run-time ratio changes for the integer clock
//                divider: waits for a divided-clock falling edge (or a
//                bounded timeout), gates the divider, loads the new ratio,
//                re-enables it and waits one settle interval before
//                acknowledging with a single-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ratio_ctrl #(
    parameter int RATIO_WIDTH   = 4,
    parameter int DEFAULT_RATIO = 1,
    parameter int GATE_CYCLES   = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    input  logic [RATIO_WIDTH-1:0] i_req_ratio,
    output logic                   o_req_ready,
    input  logic                   i_div_clk,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int DRAIN_W  = RATIO_WIDTH + 2;
    localparam int SETTLE_W = RATIO_WIDTH + 1;
    localparam int GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    // DRAIN occupies at most 2**(RATIO_WIDTH+1)-1 cycles; exit on the last one
    localparam logic [DRAIN_W-1:0]     C_DRAIN_LAST = DRAIN_W'((2 ** (RATIO_WIDTH + 1)) - 2);
    localparam logic [DRAIN_W-1:0]     C_DRAIN_MAX  = {DRAIN_W{1'b1}};
    localparam logic [GATE_W-1:0]      C_GATE_LAST  = GATE_W'(GATE_CYCLES - 1);
    localparam logic [RATIO_WIDTH-1:0] C_DEF_RATIO  = RATIO_WIDTH'(DEFAULT_RATIO);

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_GATE   = 3'd3,
        ST_LOAD   = 3'd4,
        ST_SETTLE = 3'd5
    } state_t;

    state_t                 state_q,      state_d;
    logic [RATIO_WIDTH-1:0] ratio_q,      ratio_d;
    logic [RATIO_WIDTH-1:0] new_ratio_q,  new_ratio_d;
    logic                   clk_en_q,     clk_en_d;
    logic                   done_q,       done_d;
    logic                   div_q,        div_d;
    logic [DRAIN_W-1:0]     drain_cnt_q,  drain_cnt_d;
    logic [GATE_W-1:0]      gate_cnt_q,   gate_cnt_d;
    logic [SETTLE_W-1:0]    settle_cnt_q, settle_cnt_d;
    logic [SETTLE_W-1:0]    settle_last;
    logic                   cur_bypass;

    // Next-state and next-output computation for the ratio-change sequence
    always_comb begin
        state_d      = state_q;
        ratio_d      = ratio_q;
        new_ratio_d  = new_ratio_q;
        clk_en_d     = clk_en_q;
        done_d       = 1'b0;
        div_d        = i_div_clk;
        drain_cnt_d  = '0;
        gate_cnt_d   = '0;
        settle_cnt_d = '0;

        // Ratios 0 and 1 both mean bypass: settle for a single cycle
        settle_last = (new_ratio_q == '0) ? '0 : ({1'b0, new_ratio_q} - SETTLE_W'(1));
        cur_bypass  = (32'(ratio_q) < 32'd2);

        case (state_q)
            ST_BOOT: begin
                clk_en_d = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_req_valid) begin
                    new_ratio_d = i_req_ratio;
                    if (i_req_ratio == ratio_q) begin
                        done_d = 1'b1;
                    end else if (cur_bypass) begin
                        // No divided clock edge to wait for in bypass
                        clk_en_d = 1'b0;
                        state_d  = ST_GATE;
                    end else begin
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_cnt_d = (drain_cnt_q == C_DRAIN_MAX) ? drain_cnt_q
                                                           : drain_cnt_q + DRAIN_W'(1);
                if ((div_q && !i_div_clk) || (drain_cnt_q >= C_DRAIN_LAST)) begin
                    clk_en_d = 1'b0;
                    state_d  = ST_GATE;
                end
            end
            ST_GATE: begin
                if (gate_cnt_q == C_GATE_LAST) begin
                    ratio_d = new_ratio_q;
                    state_d = ST_LOAD;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                end
            end
            ST_LOAD: begin
                clk_en_d = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_cnt_q == settle_last) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_BOOT;
            ratio_q      <= C_DEF_RATIO;
            new_ratio_q  <= '0;
            clk_en_q     <= 1'b0;
            done_q       <= 1'b0;
            div_q        <= 1'b0;
            drain_cnt_q  <= '0;
            gate_cnt_q   <= '0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            new_ratio_q  <= new_ratio_d;
            clk_en_q     <= clk_en_d;
            done_q       <= done_d;
            div_q        <= div_d;
            drain_cnt_q  <= drain_cnt_d;
            gate_cnt_q   <= gate_cnt_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_div_ratio = ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ratio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clk_div_ratio_ctrl
//  Description : Directed bench for clk_div_ratio_ctrl with a small
//                behavioural divider driving i_div_clk.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_ratio_ctrl;

    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic [RW-1:0] req_ratio = '0;
    logic          req_ready;
    logic          div_clk;
    logic [RW-1:0] div_ratio;
    logic          clk_en;
    logic          busy;
    logic          done;

    logic          force_hi = 1'b0;
    logic [RW-1:0] mdl_cnt;
    logic          mdl_div;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clk_div_ratio_ctrl #(.RATIO_WIDTH(RW), .DEFAULT_RATIO(1), .GATE_CYCLES(2)) dut (
        .i_ref_clk   (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_ratio (req_ratio),
        .o_req_ready (req_ready),
        .i_div_clk   (div_clk),
        .o_div_ratio (div_ratio),
        .o_clk_en    (clk_en),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Behavioural divider: high for the first ratio/2 counts of each period
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_cnt <= '0;
            mdl_div <= 1'b0;
        end else if (!clk_en || div_ratio < 2) begin
            mdl_cnt <= '0;
            mdl_div <= 1'b0;
        end else begin
            mdl_cnt <= (mdl_cnt == div_ratio - 1) ? '0 : mdl_cnt + 1'b1;
            mdl_div <= (((mdl_cnt == div_ratio - 1) ? 0 : 32'(mdl_cnt) + 1) < 32'(div_ratio) / 2);
        end
    end

    assign div_clk = force_hi ? 1'b1 : mdl_div;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int n = 0;
        while (done !== 1'b1 && n < max_cyc) begin
            cyc();
            n++;
        end
        chk(tag, {31'd0, done}, 32'd1);
    endtask

    task automatic st(input string tag, input logic e, input logic [RW-1:0] r,
                      input logic b, input logic d);
        chk({tag, "_en"},    {31'd0, clk_en}, {31'd0, e});
        chk({tag, "_ratio"}, {28'd0, div_ratio}, {28'd0, r});
        chk({tag, "_busy"},  {31'd0, busy}, {31'd0, b});
        chk({tag, "_done"},  {31'd0, done}, {31'd0, d});
    endtask

    initial begin
        logic h1, h2, fell;
        int   n;

        // ---- 1: reset and boot ----
        @(negedge clk);
        @(negedge clk);
        st("rst", 1'b0, 4'd1, 1'b1, 1'b0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        rst_n = 1'b1;
        cyc();
        st("boot", 1'b1, 4'd1, 1'b0, 1'b0);
        chk("boot_ready", {31'd0, req_ready}, 32'd1);

        // ---- 2: bypass 1 -> 4, DRAIN skipped ----
        req_valid = 1'b1; req_ratio = 4'd4;
        cyc(); req_valid = 1'b0;
        st("g0", 1'b0, 4'd1, 1'b1, 1'b0);
        chk("g0_ready", {31'd0, req_ready}, 32'd0);
        cyc(); st("g1",   1'b0, 4'd1, 1'b1, 1'b0);
        cyc(); st("load", 1'b0, 4'd4, 1'b1, 1'b0);
        cyc(); st("s0",   1'b1, 4'd4, 1'b1, 1'b0);
        cyc(); st("s1",   1'b1, 4'd4, 1'b1, 1'b0);
        cyc(); st("s2",   1'b1, 4'd4, 1'b1, 1'b0);
        cyc(); st("s3",   1'b1, 4'd4, 1'b1, 1'b0);
        cyc(); st("done4", 1'b1, 4'd4, 1'b0, 1'b1);
        cyc(); st("post4", 1'b1, 4'd4, 1'b0, 1'b0);

        // ---- move to ratio 6 ----
        req_valid = 1'b1; req_ratio = 4'd6;
        cyc(); req_valid = 1'b0;
        wait_done("done6", 60);
        chk("ratio6", {28'd0, div_ratio}, 32'd6);
        cyc(); cyc(); cyc(); cyc();

        // ---- 3: 6 -> 3, enable falls right after a divided-clock falling edge ----
        req_valid = 1'b1; req_ratio = 4'd3;
        h1 = div_clk; h2 = 1'b0;
        cyc(); req_valid = 1'b0;
        chk("drain_en", {31'd0, clk_en}, 32'd1);
        chk("drain_busy", {31'd0, busy}, 32'd1);
        fell = 1'b0; n = 0;
        while (!fell && n < 40) begin
            h2 = h1; h1 = div_clk;
            cyc();
            n++;
            if (!clk_en) fell = 1'b1;
        end
        chk("fall_seen", {31'd0, fell}, 32'd1);
        chk("fall_edge", {30'd0, h2, h1}, 32'b10);
        chk("fall_ratio", {28'd0, div_ratio}, 32'd6);
        wait_done("done3", 40);
        chk("ratio3", {28'd0, div_ratio}, 32'd3);

        // ---- 4: equal request handshaking in the done cycle ----
        req_valid = 1'b1; req_ratio = 4'd3;
        cyc(); req_valid = 1'b0;
        st("eq", 1'b1, 4'd3, 1'b0, 1'b1);
        chk("eq_ready", {31'd0, req_ready}, 32'd1);
        cyc(); st("eq_post", 1'b1, 4'd3, 1'b0, 1'b0);

        // ---- 5: divided clock stuck high, 3 -> 2 via timeout; valid held busy ----
        force_hi = 1'b1;
        req_valid = 1'b1; req_ratio = 4'd2;
        cyc(); req_ratio = 4'd7;
        chk("to_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while (clk_en === 1'b1 && n < 60) begin
            cyc();
            n++;
        end
        chk("to_cycles", n, 32'd31);
        chk("to_ready", {31'd0, req_ready}, 32'd0);
        cyc(); st("to_g1", 1'b0, 4'd3, 1'b1, 1'b0);
        cyc(); st("to_load", 1'b0, 4'd2, 1'b1, 1'b0);
        req_valid = 1'b0;
        cyc(); st("to_s0", 1'b1, 4'd2, 1'b1, 1'b0);
        cyc(); st("to_s1", 1'b1, 4'd2, 1'b1, 1'b0);
        cyc(); st("to_done", 1'b1, 4'd2, 1'b0, 1'b1);
        force_hi = 1'b0;
        cyc(); cyc();
        st("to_idle", 1'b1, 4'd2, 1'b0, 1'b0);

        // ---- 6: reset asserted during GATE ----
        req_valid = 1'b1; req_ratio = 4'd5;
        cyc(); req_ratio = 4'd9;
        n = 0;
        while (clk_en === 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk("r_gate", {31'd0, clk_en}, 32'd0);
        rst_n = 1'b0;
        #1;
        st("r_now", 1'b0, 4'd1, 1'b1, 1'b0);
        req_valid = 1'b0;
        cyc(); chk("r_nodone0", {31'd0, done}, 32'd0);
        cyc(); chk("r_nodone1", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        cyc(); st("r_boot", 1'b1, 4'd1, 1'b0, 1'b0);
        cyc(); st("r_idle", 1'b1, 4'd1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
